// File: rtl/activity_pkg.sv
// activity_pkg: display encodings and default parameters shared by the activity tracker
package activity_pkg;
  typedef enum logic [1:0] {DISP_STEPS, DISP_DIST, DISP_INIT, DISP_HIGH} disp_mode_e;
  localparam int STEP_W_DEF = 32;
  localparam int RATE_W_DEF = 12;
  localparam int SI_THRESHOLD_DEF = 10000;
  localparam int STEPS_PER_TENTH_DEF = 2048;
  localparam int INIT_WINDOW_DEF = 10;
  localparam int INIT_RATE_DEF = 32;
  localparam int HIGH_RATE_DEF = 64;
  localparam int HIGH_MIN_SEC_DEF = 60;
  localparam int DISP_SEC_DEF = 2;
endpackage

// File: rtl/step_edge_detect.sv
// step_edge_detect: one-cycle strobe on an enabled rising edge of STEP
module step_edge_detect (
  input  logic CLK,
  input  logic RESET_N,
  input  logic ENABLE,
  input  logic STEP,
  output logic STROBE
);
  logic prev;
  // prev tracks STEP even while paused so resuming with STEP high is not a step
  always_ff @(posedge CLK) prev <= RESET_N ? STEP : 1'b0;
  assign STROBE = ENABLE & STEP & ~prev;
endmodule

// File: rtl/activity_tracker.sv
// activity_tracker: step, distance, per-second rate and high-activity tracking with rotating display
module activity_tracker
  import activity_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int RATE_W = RATE_W_DEF,
  parameter int SI_THRESHOLD = SI_THRESHOLD_DEF,
  parameter int STEPS_PER_TENTH = STEPS_PER_TENTH_DEF,
  parameter int INIT_WINDOW = INIT_WINDOW_DEF,
  parameter int INIT_RATE = INIT_RATE_DEF,
  parameter int HIGH_RATE = HIGH_RATE_DEF,
  parameter int HIGH_MIN_SEC = HIGH_MIN_SEC_DEF,
  parameter int DISP_SEC = DISP_SEC_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              STEP,
  input  logic              SEC_TICK,
  input  logic              HOLD,
  output logic              SI,
  output logic [STEP_W-1:0] STEP_COUNT,
  output logic [15:0]       DISTANCE,
  output logic [3:0]        INIT_COUNT,
  output logic [15:0]       HIGH_TIME,
  output logic [RATE_W-1:0] LAST_RATE,
  output logic [RATE_W-1:0] PEAK_RATE,
  output logic [1:0]        DISP_MODE,
  output logic [15:0]       DISP_VALUE
);
  localparam int ACC_W = $clog2(STEPS_PER_TENTH + 1);
  localparam logic [ACC_W-1:0] ACC_TOP = ACC_W'(STEPS_PER_TENTH - 1);
  localparam logic [STEP_W-1:0] SI_TH = STEP_W'(SI_THRESHOLD);
  localparam logic [STEP_W-1:0] DISP_CAP = STEP_W'(16'hFFFF);
  localparam logic [RATE_W-1:0] INIT_TH = RATE_W'(INIT_RATE);
  localparam logic [RATE_W-1:0] HIGH_TH = RATE_W'(HIGH_RATE);
  localparam logic [15:0] INIT_WIN = 16'(INIT_WINDOW);
  localparam logic [15:0] HIGH_MIN = 16'(HIGH_MIN_SEC);
  localparam logic [7:0] DISP_TOP = 8'(DISP_SEC - 1);
  logic step, tick;
  logic [ACC_W-1:0] acc;
  logic [RATE_W-1:0] rate;
  logic [15:0] elapsed, run, run_nx, high_add;
  logic [16:0] high_sum;
  logic [7:0] disp_tick;
  disp_mode_e mode;
  step_edge_detect u_edge (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .ENABLE(ENABLE),
    .STEP(STEP),
    .STROBE(step)
  );
  assign tick = ENABLE & SEC_TICK;
  assign run_nx = &run ? run : run + 16'd1;
  // reaching the minimum run credits the whole run at once, then one per second after
  assign high_add = run_nx == HIGH_MIN ? HIGH_MIN : run_nx > HIGH_MIN ? 16'd1 : 16'd0;
  assign high_sum = {1'b0, HIGH_TIME} + {1'b0, high_add};
  assign DISP_MODE = mode;
  always_comb
    DISP_VALUE = mode == DISP_STEPS ? (STEP_COUNT > DISP_CAP ? 16'hFFFF : STEP_COUNT[15:0]) :
                 mode == DISP_DIST  ? DISTANCE :
                 mode == DISP_INIT  ? {12'd0, INIT_COUNT} : HIGH_TIME;
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      SI <= 1'b0;
      STEP_COUNT <= '0;
      DISTANCE <= '0;
      INIT_COUNT <= '0;
      HIGH_TIME <= '0;
      LAST_RATE <= '0;
      PEAK_RATE <= '0;
      acc <= '0;
      rate <= '0;
      elapsed <= '0;
      run <= '0;
      disp_tick <= '0;
      mode <= DISP_STEPS;
    end else begin
      SI <= SI | (STEP_COUNT >= SI_TH);
      if (step) begin
        if (!(&STEP_COUNT)) STEP_COUNT <= STEP_COUNT + STEP_W'(1);
        acc <= acc == ACC_TOP ? '0 : acc + ACC_W'(1);
        if (acc == ACC_TOP && !(&DISTANCE)) DISTANCE <= DISTANCE + 16'd1;
      end
      if (tick) begin
        LAST_RATE <= rate;
        rate <= RATE_W'(step);
        if (rate > PEAK_RATE) PEAK_RATE <= rate;
        if (!(&elapsed)) elapsed <= elapsed + 16'd1;
        if (elapsed < INIT_WIN && rate > INIT_TH && !(&INIT_COUNT)) INIT_COUNT <= INIT_COUNT + 4'd1;
        if (rate >= HIGH_TH) begin
          run <= run_nx;
          HIGH_TIME <= high_sum[16] ? 16'hFFFF : high_sum[15:0];
        end else run <= '0;
        if (!HOLD) begin
          disp_tick <= disp_tick == DISP_TOP ? '0 : disp_tick + 8'd1;
          if (disp_tick == DISP_TOP) mode <= disp_mode_e'(mode + 2'd1);
        end
      end else if (step && !(&rate)) rate <= rate + RATE_W'(1);
    end
  end
endmodule
